// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbiter: FSM encoding and
// default sizing of the requester pool, frame lock and start watchdog.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tx_state_e;

    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_MAX_FRAME     = 16;
    localparam int DEF_START_TIMEOUT = 1024;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request strictly after
// last_grant_i (wrapping), returned both one-hot and as an index.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_grant_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] grant_idx_o,
    output logic                 grant_valid_o
);

    localparam int            IW       = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [IW-1:0] cand;

    // Walk the ring once starting just past the previous owner; the first hit wins.
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        cand          = (last_grant_i >= LAST_IDX) ? '0 : last_grant_i + 1'b1;
        for (int k = 0; k < N; k++) begin
            if (!grant_valid_o && req_i[cand]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = cand;
                grant_o[cand] = 1'b1;
            end
            cand = (cand >= LAST_IDX) ? '0 : cand + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte sources with per-byte
// round-robin, a frame lock for multi-byte frames and a start watchdog.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int MAX_FRAME     = DEF_MAX_FRAME,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_clear,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       lock_active,
    output logic                       timeout_err
);

    localparam int            IW       = $clog2(NUM_REQ);
    localparam int            CW       = $clog2(MAX_FRAME + 1);
    localparam int            TW       = $clog2(START_TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);

    tx_state_e     state_q, state_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [IW-1:0] grant_q, grant_d;
    logic          lock_q, lock_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;

    logic [7:0]         req_byte [NUM_REQ];
    logic [NUM_REQ-1:0] owner_mask;
    logic [NUM_REQ-1:0] rr_onehot;
    logic [IW-1:0]      rr_idx;
    logic               rr_valid;
    logic [IW-1:0]      winner_idx;
    logic               accept;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_byte[gi]   = req_data[8*gi +: 8];
        assign owner_mask[gi] = (grant_q == IW'(gi));
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req_i         (req_valid),
        .last_grant_i  (grant_q),
        .grant_o       (rr_onehot),
        .grant_idx_o   (rr_idx),
        .grant_valid_o (rr_valid)
    );

    // While a frame is locked only the owner may be served; otherwise round-robin.
    always_comb begin
        req_ready  = '0;
        winner_idx = lock_q ? grant_q : rr_idx;
        if (state_q == ST_IDLE) begin
            req_ready = lock_q ? (req_valid & owner_mask) : (rr_valid ? rr_onehot : '0);
        end
        accept = |req_ready;
    end

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        lock_d    = lock_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tx_data_d = req_byte[winner_idx];
                    grant_d   = winner_idx;
                    tmo_d     = '0;
                    state_d   = ST_START;
                    // Release on the frame's last byte or once the frame hits its length cap.
                    if (!req_last[winner_idx] && (int'(cnt_q) + 1 < MAX_FRAME)) begin
                        lock_d = 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                    end else begin
                        lock_d = 1'b0;
                        cnt_d  = '0;
                    end
                end
            end
            ST_START: begin
                if (tx_clear) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_q >= TMO_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    lock_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                // Entered the cycle after tx_clear, so busy is first sampled here.
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tx_data_q <= '0;
            grant_q   <= LAST_IDX;
            lock_q    <= 1'b0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            lock_q    <= lock_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
        end
    end

    assign tx_start    = (state_q == ST_START);
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign lock_active = lock_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a transmitter stub and a
// transaction-level arbitration model checked on every accept.
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int MAXF = 4;
    localparam int TMO  = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_clear;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           lock_active;
    logic           timeout_err;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .MAX_FRAME     (MAXF),
        .START_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_clear    (tx_clear),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .lock_active (lock_active),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Requester byte queues
    logic [7:0] bd [N][32];
    logic       bl [N][32];
    int         head [N];
    int         tail [N];

    task automatic push(input int r, input logic [7:0] d, input logic last);
        bd[r][tail[r]] = d;
        bl[r][tail[r]] = last;
        tail[r]++;
    endtask

    // Arbitration model: expected grant sequence for the bytes currently queued
    typedef struct {
        int         owner;
        logic [7:0] data;
        logic       lock;
    } exp_t;

    exp_t exp_q[$];
    int   obs_owner[$];
    logic obs_lock[$];
    int   m_ptr  = N - 1;
    bit   m_lock = 1'b0;
    int   m_cnt  = 0;
    bit   clear_en = 1'b1;

    task automatic model_batch(input bit tmo);
        int   pos [N];
        int   owner;
        exp_t e;
        for (int i = 0; i < N; i++) pos[i] = head[i];
        forever begin
            owner = -1;
            if (m_lock) begin
                if (pos[m_ptr] < tail[m_ptr]) owner = m_ptr;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (owner < 0 && pos[(m_ptr + k) % N] < tail[(m_ptr + k) % N])
                        owner = (m_ptr + k) % N;
                end
            end
            if (owner < 0) break;
            e.owner = owner;
            e.data  = bd[owner][pos[owner]];
            if (!bl[owner][pos[owner]] && m_cnt + 1 < MAXF) begin
                m_lock = 1'b1;
                m_cnt  = m_cnt + 1;
            end else begin
                m_lock = 1'b0;
                m_cnt  = 0;
            end
            e.lock = m_lock;
            exp_q.push_back(e);
            pos[owner]++;
            m_ptr = owner;
            if (tmo) begin
                m_lock = 1'b0;
                m_cnt  = 0;
            end
        end
    endtask

    // Sequences are written as hex nibbles, leftmost = first transaction.
    task automatic chk_model(input string name, input int n, input logic [31:0] own, input logic [31:0] lck);
        chk({name, "_model_len"}, exp_q.size(), n);
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            chk({name, "_model_owner"}, exp_q[i].owner, own[4*(n-1-i) +: 4]);
            chk({name, "_model_lock"}, exp_q[i].lock, lck[4*(n-1-i) +: 4]);
        end
    endtask

    task automatic chk_obs(input string name, input int n, input logic [31:0] own, input logic [31:0] lck);
        chk({name, "_obs_len"}, obs_owner.size(), n);
        for (int i = 0; i < n && i < obs_owner.size() && i < obs_lock.size(); i++) begin
            chk({name, "_obs_owner"}, obs_owner[i], own[4*(n-1-i) +: 4]);
            chk({name, "_obs_lock"}, obs_lock[i], lck[4*(n-1-i) +: 4]);
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        int stable = 0;
        int n = 0;
        while (stable < 3 && n < limit) begin
            @(negedge clk);
            n++;
            if (exp_q.size() == 0 && !tx_start && !tx_busy && req_valid == '0) stable++;
            else stable = 0;
        end
        chk({name, "_idle_reached"}, stable >= 3, 1);
    endtask

    // Requester driver: retire accepted bytes, then present the next ones
    initial begin
        logic [N-1:0] acc;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) head[i]++;
                req_valid[i]        = head[i] < tail[i];
                req_data[8*i +: 8]  = (head[i] < tail[i]) ? bd[i][head[i]] : 8'h00;
                req_last[i]         = (head[i] < tail[i]) ? bl[i][head[i]] : 1'b0;
            end
        end
    end

    // Transmitter stub: clear one cycle after tx_start is seen, busy for 10 cycles
    initial begin
        tx_clear = 1'b0;
        tx_busy  = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && clear_en && rst_n) begin
                @(posedge clk);
                #1;
                tx_clear = 1'b1;
                tx_busy  = 1'b1;
                @(posedge clk);
                #1;
                tx_clear = 1'b0;
                repeat (9) @(posedge clk);
                #1;
                tx_busy = 1'b0;
            end
        end
    end

    // Compare process: every accept must match the next model transaction
    initial begin
        exp_t         cur;
        bit           pend;
        int           idx;
        logic [N-1:0] acc;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("start_after_accept", tx_start, 1);
                    chk("tx_data", tx_data, cur.data);
                    chk("grant_id", grant_id, cur.owner);
                    chk("lock_active", lock_active, cur.lock);
                    obs_lock.push_back(lock_active);
                    pend = 1'b0;
                end
                chk("ready_onehot", ($countones(req_ready) <= 1) && ((req_ready & ~req_valid) == '0), 1);
                acc = req_valid & req_ready;
                if (acc != '0) begin
                    idx = 0;
                    for (int i = 0; i < N; i++) if (acc[i]) idx = i;
                    obs_owner.push_back(idx);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_accept", acc, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("ready_owner", req_ready, 1 << cur.owner);
                        pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary expected one");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values
        chk("rst_req_ready", req_ready, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant_id", grant_id, N - 1);
        chk("rst_lock", lock_active, 0);
        chk("rst_timeout_err", timeout_err, 0);

        // Single byte
        push(0, 8'h55, 1'b1);
        model_batch(1'b0);
        chk_model("t2", 1, 32'h0, 32'h0);
        n = 0;
        while (req_ready == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t2_ready", req_ready, 4'b0001);
        @(negedge clk);
        chk("t2_start", tx_start, 1);
        chk("t2_data", tx_data, 8'h55);
        chk("t2_ready_drop", req_ready, 0);
        @(negedge clk);
        chk("t2_start_in_clear_cycle", tx_start, 1);
        @(negedge clk);
        chk("t2_start_dropped", tx_start, 0);
        chk("t2_busy_seen", tx_busy, 1);
        wait_idle("t2", 60);
        chk("t2_grant", grant_id, 0);
        chk("t2_lock", lock_active, 0);

        // Reset while in START
        clear_en = 1'b0;
        push(1, 8'hA1, 1'b1);
        model_batch(1'b0);
        n = 0;
        while (!tx_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t1_start_seen", tx_start, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_tx_start", tx_start, 0);
        chk("t1_rst_grant", grant_id, N - 1);
        chk("t1_rst_tx_data", tx_data, 0);
        chk("t1_rst_ready", req_ready, 0);
        chk("t1_byte_consumed", exp_q.size(), 0);
        m_ptr  = N - 1;
        m_lock = 1'b0;
        m_cnt  = 0;
        exp_q.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        clear_en = 1'b1;
        @(negedge clk);
        chk("t1_idle_after_rst", tx_start, 0);

        // Round-robin contention
        obs_owner.delete();
        obs_lock.delete();
        push(0, 8'h10, 1'b1);
        push(1, 8'h21, 1'b1);
        push(2, 8'h32, 1'b1);
        push(3, 8'h43, 1'b1);
        push(0, 8'h14, 1'b1);
        model_batch(1'b0);
        chk_model("t3", 5, 32'h01230, 32'h00000);
        wait_idle("t3", 400);
        chk_obs("t3", 5, 32'h01230, 32'h00000);

        // Frame lock
        obs_owner.delete();
        obs_lock.delete();
        push(1, 8'hA0, 1'b0);
        push(1, 8'hA1, 1'b0);
        push(1, 8'hA2, 1'b1);
        push(2, 8'hB0, 1'b1);
        model_batch(1'b0);
        chk_model("t4", 4, 32'h1112, 32'h1100);
        wait_idle("t4", 300);
        chk_obs("t4", 4, 32'h1112, 32'h1100);

        // Forced release after MAX_FRAME bytes
        push(3, 8'hD0, 1'b1);
        model_batch(1'b0);
        wait_idle("t5a", 100);
        obs_owner.delete();
        obs_lock.delete();
        push(0, 8'hE0, 1'b0);
        push(0, 8'hE1, 1'b0);
        push(0, 8'hE2, 1'b0);
        push(0, 8'hE3, 1'b0);
        push(0, 8'hE4, 1'b0);
        push(0, 8'hE5, 1'b1);
        push(3, 8'hD1, 1'b1);
        model_batch(1'b0);
        chk_model("t5", 7, 32'h0000300, 32'h1110010);
        wait_idle("t5", 500);
        chk_obs("t5", 7, 32'h0000300, 32'h1110010);

        // Start timeout
        clear_en = 1'b0;
        obs_owner.delete();
        obs_lock.delete();
        push(2, 8'hC2, 1'b1);
        push(3, 8'hC3, 1'b1);
        model_batch(1'b1);
        chk_model("t6", 2, 32'h23, 32'h00);
        n = 0;
        while (!tx_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_start_seen", tx_start, 1);
        w = 1;
        @(negedge clk);
        while (tx_start && w < 30) begin
            w++;
            @(negedge clk);
        end
        chk("t6_start_width", w, TMO);
        chk("t6_timeout_err", timeout_err, 1);
        wait_idle("t6", 100);
        chk_obs("t6", 2, 32'h23, 32'h00);
        chk("t6_err_sticky", timeout_err, 1);
        chk("t6_lock_cleared", lock_active, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
